// File: rtl/interval_countdown_timer_pkg.sv
// Shared encodings for the interval countdown timer and the workout FSM it feeds.
package interval_countdown_timer_pkg;

  localparam int DUR_W_DEF = 8;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_WORKOUT = 2'b01,
    PH_REST    = 2'b10,
    PH_FINISH  = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    T_IDLE    = 2'b00,
    T_RUN     = 2'b01,
    T_EXPIRED = 2'b10
  } tstate_e;

endpackage

// File: rtl/interval_countdown_timer_if.sv
// Timer control/status bundle between the workout FSM (master) and the timer (slave).
// Optional macro WARN_EN adds the end-of-rest warn pulse.
interface interval_countdown_timer_if
  import interval_countdown_timer_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
) ();

  logic             start_timer;
  logic [1:0]       state_in;
  logic [DUR_W-1:0] work_sec;
  logic [DUR_W-1:0] rest_sec;
  logic             time_done;
  logic [DUR_W-1:0] remaining;
  logic [2:0]       disp_min;
  logic [2:0]       disp_sec_tens;
  logic [3:0]       disp_sec_ones;
  tstate_e          tstate;
`ifdef WARN_EN
  logic             warn;
`endif

  // Inputs are level signals sampled every clk; time_done and warn are single-cycle pulses.
  modport master (
    output start_timer, state_in, work_sec, rest_sec,
    input  time_done, remaining, disp_min, disp_sec_tens, disp_sec_ones, tstate
`ifdef WARN_EN
    , input warn
`endif
  );

  modport slave (
    input  start_timer, state_in, work_sec, rest_sec,
    output time_done, remaining, disp_min, disp_sec_tens, disp_sec_ones, tstate
`ifdef WARN_EN
    , output warn
`endif
  );

endinterface

// File: rtl/interval_countdown_timer_sec_to_mmss.sv
// Combinational split of a seconds count into minutes, tens of seconds and ones of seconds.
module sec_to_mmss #(
  parameter int DUR_W = 8
) (
  input  logic [DUR_W-1:0] sec,
  output logic [2:0]       min,
  output logic [2:0]       tens,
  output logic [3:0]       ones
);

  logic [DUR_W-1:0] sec_in_min;

  assign min        = 3'(sec / DUR_W'(60));
  assign sec_in_min = sec % DUR_W'(60);
  assign tens       = 3'(sec_in_min / DUR_W'(10));
  assign ones       = 4'(sec_in_min % DUR_W'(10));

endmodule

// File: rtl/interval_countdown_timer.sv
// Interval countdown timer: reloads on phase change, ticks once per second, pulses time_done.
// Optional macro WARN_EN adds a warn pulse on the last three seconds of a rest phase.
module interval_countdown_timer
  import interval_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int DUR_W    = DUR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  interval_countdown_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  tstate_e          tstate, tstate_d;
  logic [1:0]       phase_q;
  logic [PW-1:0]    prescaler, prescaler_d;
  logic [DUR_W-1:0] remaining, remaining_d, selected;
  logic             time_done, time_done_d;
  logic             go_idle, load, tick;
  logic [2:0]       min_w, tens_w, disp_min, disp_tens;
  logic [3:0]       ones_w, disp_ones;
`ifdef WARN_EN
  logic             warn, warn_d;
`endif

  // Any non-running phase or a dropped enable wins over load; load wins over tick.
  assign go_idle  = !bus.start_timer || (bus.state_in == PH_IDLE) || (bus.state_in == PH_FINISH);
  assign load     = !go_idle && ((bus.state_in != phase_q) || (tstate == T_IDLE));
  assign selected = (bus.state_in == PH_REST) ? bus.rest_sec : bus.work_sec;
  assign tick     = (tstate == T_RUN) && (prescaler == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) tstate <= T_IDLE;
    else       tstate <= tstate_d;
  end

  always_comb begin
    tstate_d = tstate;
    if (go_idle)                                          tstate_d = T_IDLE;
    else if (load)                                        tstate_d = (selected == '0) ? T_EXPIRED : T_RUN;
    else if (tick && (remaining <= DUR_W'(1)))            tstate_d = T_EXPIRED;
  end

  always_comb begin
    remaining_d = remaining;
    time_done_d = 1'b0;
    prescaler_d = '0;
`ifdef WARN_EN
    warn_d      = 1'b0;
`endif
    if (go_idle) begin
      remaining_d = '0;
    end else if (load) begin
      // A zero duration expires straight away rather than sitting in T_RUN.
      remaining_d = selected;
      time_done_d = (selected == '0);
    end else if (tick) begin
      if (remaining > DUR_W'(1)) begin
        remaining_d = remaining - DUR_W'(1);
`ifdef WARN_EN
        warn_d = (bus.state_in == PH_REST) && (remaining <= DUR_W'(4));
`endif
      end else begin
        remaining_d = '0;
        time_done_d = 1'b1;
      end
    end else if (tstate == T_RUN) begin
      prescaler_d = prescaler + PW'(1);
    end
  end

  sec_to_mmss #(.DUR_W(DUR_W)) u_mmss (
    .sec  (remaining),
    .min  (min_w),
    .tens (tens_w),
    .ones (ones_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_IDLE;
      prescaler <= '0;
      remaining <= '0;
      time_done <= 1'b0;
      disp_min  <= '0;
      disp_tens <= '0;
      disp_ones <= '0;
`ifdef WARN_EN
      warn      <= 1'b0;
`endif
    end else begin
      phase_q   <= bus.state_in;
      prescaler <= prescaler_d;
      remaining <= remaining_d;
      time_done <= time_done_d;
      disp_min  <= min_w;
      disp_tens <= tens_w;
      disp_ones <= ones_w;
`ifdef WARN_EN
      warn      <= warn_d;
`endif
    end
  end

  assign bus.time_done     = time_done;
  assign bus.remaining     = remaining;
  assign bus.disp_min      = disp_min;
  assign bus.disp_sec_tens = disp_tens;
  assign bus.disp_sec_ones = disp_ones;
  assign bus.tstate        = tstate;
`ifdef WARN_EN
  assign bus.warn          = warn;
`endif

endmodule

// File: tb/tb_interval_countdown_timer.sv
// Directed bench for interval_countdown_timer at TICK_DIV=4; warn checks only when WARN_EN is defined.
module tb_interval_countdown_timer;
  import interval_countdown_timer_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  interval_countdown_timer_if #(.DUR_W(DUR_W)) bus ();

  interval_countdown_timer #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start_timer = 1'b0;
    bus.state_in = 2'b00;
    bus.work_sec = '0;
    bus.rest_sec = '0;
    step(); step(); step();
    checks++;
    if (bus.remaining !== 8'd0) begin $display("FAIL reset_remaining got %0d want 0", bus.remaining); errors++; end
    checks++;
    if (bus.time_done !== 1'b0) begin $display("FAIL reset_time_done got %b want 0", bus.time_done); errors++; end
    checks++;
    if ({bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones} !== 10'd0) begin
      $display("FAIL reset_disp got %0d:%0d%0d want 0:00", bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones); errors++;
    end
    checks++;
    if (bus.tstate !== T_IDLE) begin $display("FAIL reset_tstate got %0d want %0d", bus.tstate, T_IDLE); errors++; end
`ifdef WARN_EN
    checks++;
    if (bus.warn !== 1'b0) begin $display("FAIL reset_warn got %b want 0", bus.warn); errors++; end
`endif
    reset = 1'b0;
    step();
  endtask

  // work=3: ticks every 4 cycles after the load, expiry pulse at k=12.
  task automatic test_countdown();
    logic [7:0] exp_rem;
    bus.work_sec = 8'd3;
    bus.state_in = 2'b01;
    bus.start_timer = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      step();
      exp_rem = (k < 12) ? 8'(3 - k / 4) : 8'd0;
      checks++;
      if (bus.remaining !== exp_rem) begin $display("FAIL countdown_remaining k=%0d got %0d want %0d", k, bus.remaining, exp_rem); errors++; end
      checks++;
      if (bus.time_done !== (k == 12)) begin $display("FAIL countdown_time_done k=%0d got %b want %b", k, bus.time_done, (k == 12)); errors++; end
`ifdef WARN_EN
      checks++;
      if (bus.warn !== 1'b0) begin $display("FAIL countdown_warn k=%0d got %b want 0", k, bus.warn); errors++; end
`endif
      if (k == 0) begin
        checks++;
        if (bus.tstate !== T_RUN) begin $display("FAIL countdown_tstate_run got %0d want %0d", bus.tstate, T_RUN); errors++; end
      end
      if (k == 1) begin
        checks++;
        if ({bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones} !== {3'd0, 3'd0, 4'd3}) begin
          $display("FAIL countdown_disp_start got %0d:%0d%0d want 0:03", bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones); errors++;
        end
      end
      if (k == 13) begin
        checks++;
        if ({bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones} !== 10'd0) begin
          $display("FAIL countdown_disp_end got %0d:%0d%0d want 0:00", bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones); errors++;
        end
        checks++;
        if (bus.tstate !== T_EXPIRED) begin $display("FAIL countdown_tstate_expired got %0d want %0d", bus.tstate, T_EXPIRED); errors++; end
      end
    end
  endtask

  // Phase change 01->10 after expiry reloads rest=2; expiry 8 cycles after the load.
  task automatic test_rest_reload();
    logic [7:0] exp_rem;
    bus.rest_sec = 8'd2;
    bus.state_in = 2'b10;
    for (int k = 0; k <= 8; k++) begin
      step();
      exp_rem = (k < 4) ? 8'd2 : ((k < 8) ? 8'd1 : 8'd0);
      checks++;
      if (bus.remaining !== exp_rem) begin $display("FAIL rest_remaining k=%0d got %0d want %0d", k, bus.remaining, exp_rem); errors++; end
      checks++;
      if (bus.time_done !== (k == 8)) begin $display("FAIL rest_time_done k=%0d got %b want %b", k, bus.time_done, (k == 8)); errors++; end
`ifdef WARN_EN
      checks++;
      if (bus.warn !== (k == 4)) begin $display("FAIL rest_warn k=%0d got %b want %b", k, bus.warn, (k == 4)); errors++; end
`endif
    end
    checks++;
    if (bus.tstate !== T_EXPIRED) begin $display("FAIL rest_tstate got %0d want %0d", bus.tstate, T_EXPIRED); errors++; end
  endtask

  task automatic test_zero_duration();
    bus.work_sec = 8'd0;
    bus.state_in = 2'b01;
    step();
    checks++;
    if (bus.time_done !== 1'b1) begin $display("FAIL zero_time_done got %b want 1", bus.time_done); errors++; end
    checks++;
    if (bus.remaining !== 8'd0) begin $display("FAIL zero_remaining got %0d want 0", bus.remaining); errors++; end
    checks++;
    if (bus.tstate !== T_EXPIRED) begin $display("FAIL zero_tstate got %0d want %0d", bus.tstate, T_EXPIRED); errors++; end
    step();
    checks++;
    if (bus.time_done !== 1'b0) begin $display("FAIL zero_time_done_drop got %b want 0", bus.time_done); errors++; end
  endtask

  task automatic test_reset_mid_run();
    bus.rest_sec = 8'd5;
    bus.state_in = 2'b10;
    step();
    checks++;
    if (bus.remaining !== 8'd5) begin $display("FAIL midreset_load got %0d want 5", bus.remaining); errors++; end
    reset = 1'b1;
    bus.start_timer = 1'b0;
    step();
    checks++;
    if (bus.remaining !== 8'd0) begin $display("FAIL midreset_remaining got %0d want 0", bus.remaining); errors++; end
    checks++;
    if (bus.tstate !== T_IDLE) begin $display("FAIL midreset_tstate got %0d want %0d", bus.tstate, T_IDLE); errors++; end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus.time_done !== 1'b0 || bus.remaining !== 8'd0) begin
        $display("FAIL midreset_quiet k=%0d got done=%b rem=%0d want done=0 rem=0", k, bus.time_done, bus.remaining); errors++;
      end
      step();
    end
  endtask

  // Phase change lands on the tick edge at remaining=2: reload wins, no decrement.
  task automatic test_tick_reload();
    bus.work_sec = 8'd2;
    bus.state_in = 2'b01;
    bus.start_timer = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      step();
      checks++;
      if (bus.remaining !== 8'd2) begin $display("FAIL tickload_pre k=%0d got %0d want 2", k, bus.remaining); errors++; end
    end
    bus.rest_sec = 8'd7;
    bus.state_in = 2'b10;
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (bus.remaining !== ((k < 4) ? 8'd7 : 8'd6)) begin
        $display("FAIL tickload_remaining k=%0d got %0d want %0d", k, bus.remaining, (k < 4) ? 7 : 6); errors++;
      end
      checks++;
      if (bus.time_done !== 1'b0) begin $display("FAIL tickload_time_done k=%0d got %b want 0", k, bus.time_done); errors++; end
    end
  endtask

  task automatic test_max_and_stop();
    bus.work_sec = 8'd255;
    bus.state_in = 2'b01;
    step();
    checks++;
    if (bus.remaining !== 8'd255) begin $display("FAIL max_remaining got %0d want 255", bus.remaining); errors++; end
    step();
    checks++;
    if ({bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones} !== {3'd4, 3'd1, 4'd5}) begin
      $display("FAIL max_disp got %0d:%0d%0d want 4:15", bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones); errors++;
    end
    bus.start_timer = 1'b0;
    step();
    checks++;
    if (bus.remaining !== 8'd0) begin $display("FAIL stop_remaining got %0d want 0", bus.remaining); errors++; end
    checks++;
    if (bus.tstate !== T_IDLE) begin $display("FAIL stop_tstate got %0d want %0d", bus.tstate, T_IDLE); errors++; end
    step();
    checks++;
    if (bus.time_done !== 1'b0) begin $display("FAIL stop_time_done got %b want 0", bus.time_done); errors++; end
    checks++;
    if ({bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones} !== 10'd0) begin
      $display("FAIL stop_disp got %0d:%0d%0d want 0:00", bus.disp_min, bus.disp_sec_tens, bus.disp_sec_ones); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_rest_reload();
    test_zero_duration();
    test_reset_mid_run();
    test_tick_reload();
    test_max_and_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
